alignment_stack: RTL and testbench
==================================

// Module: alignment_stack
// PURPOSE
//  Downstream of the traceback direction counter. Watches the (i,j) walk from (N,N)-ish down to (0,0)
//  and turns each step into one aligned column: a match/mismatch pair or a gap. Columns arrive in
//  reverse order, so they are pushed onto a LIFO. After traceback ends, they are popped in forward
//  order to the output formatter over a valid/ready handshake.
// PARAMETERS
//  N        128                 max sequence length
//  BitAddr  $clog2(N+1)         coordinate width - 1 (coords are BitAddr+1 bits, same as counter)
//  SYM_W    2                   bits per sequence symbol (nucleotide code)
//  DEPTH    2*N                 LIFO entries (worst-case alignment length)
//  PAIR_W   2*(SYM_W+1)         column width = {gap_a, chr_a, gap_b, chr_b}
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous reset, active-low (0 = reset)
//  en_traceB  in   1            traceback phase active
//  end_c      in   1            traceback counter reached (0,0)
//  i, j       in   BitAddr+1    current traceback coordinates
//  char_a     in   SYM_W        seq A symbol at 1-based position i (don't-care when i=0)
//  char_b     in   SYM_W        seq B symbol at 1-based position j (don't-care when j=0)
//  out_valid  out  1            out_data holds a valid column
//  out_ready  in   1            consumer accepts column
//  out_data   out  PAIR_W       aligned column, forward order
//  out_last   out  1            current out_data is the final column
//  length     out  $clog2(DEPTH+1)  columns captured this run
//  done       out  1            drain finished; held until en_traceB falls
//  err        out  1            sticky: overflow or illegal step; cleared only in IDLE->FILL or reset
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, sp=0, length=0, out_valid=0, out_last=0, done=0, err=0,
//   out_data=0, prev_vld=0.
//  FSM: IDLE -> FILL when en_traceB=1 (err, sp, length cleared on this entry).
//   FILL -> IDLE if en_traceB=0 (run discarded, sp=0).
//   FILL -> DRAIN on end_c=1 if sp (after this cycle's push) > 0; else FILL -> DONE.
//   DRAIN -> DONE on pop of the last entry. DRAIN -> IDLE if en_traceB=0 (abort, sp=0).
//   DONE: done=1; -> IDLE when en_traceB=0.
//  Step capture (FILL only): prev_{i,j,a,b} register the last sample. The first FILL cycle only
//   loads prev (prev_vld=1); nothing is pushed. In each later cycle, di=prev_i-i and dj=prev_j-j:
//   di=0,dj=0 : hold, no push (counter stall)
//   di=1,dj=1 : push {0,prev_a,0,prev_b}  (diag)
//   di=1,dj=0 : push {1,0,0,prev_b... no: push {0,prev_a,1,0}}  (up: gap in B)
//   di=0,dj=1 : push {1,0,0,prev_b}  (left: gap in A)
//   any other : err=1, no push. prev still updates so recovery is possible.
//   prev updates every FILL cycle. Push: stack[sp]<=col; sp<=sp+1; length<=length+1.
//   A push is only possible when the coordinates change.
//  Simultaneous: a coordinate change in the same cycle as end_c=1 is still pushed before entering DRAIN.
//  Overflow: a push with sp==DEPTH sets err=1. The column is dropped; sp and length are unchanged.
//  Drain: out_valid=1 throughout DRAIN (registered, asserted the cycle after entry).
//   out_data=stack[sp-1], out_last=(sp==1). Pop on out_valid&out_ready: sp<=sp-1.
//   Throughput: 1 column/cycle. out_data must stay stable while out_valid=1 and out_ready=0.
//  length is held through DRAIN and DONE, and cleared on the next IDLE->FILL.
//  Width rules: di and dj are computed at BitAddr+2 bits, so an underflow is read as illegal, not wrapped.
// TESTING
//  1 N=4, chars A=[a1..a4], B=[b1..b4]. Coords (4,4),(3,3),(2,3),(1,2),(0,1),(0,0), then end_c, ready=1
//    -> pops in order: (-,b1),(a1,b2),(a2,b3),(a3,-),(a4,b4); out_last on the 5th; length=5; then done=1.
//  2 Same walk with each coordinate held 3 cycles -> identical output, length=5 (stalls ignored).
//  3 out_ready toggled 1,0,0,1,... during drain -> out_data stable while stalled; order unchanged; no loss.
//  4 Coords jump (3,3)->(1,3) -> err=1, no push. Later legal steps still push. err stays 1 until next run.
//  5 DEPTH=4 with 5 legal steps -> err=1; length=4; drain emits 4 columns; done=1.
//  6 rst=0 mid-DRAIN (async, off-edge) -> outputs zero immediately. Next run with an immediate end_c
//    and no steps -> DONE with length=0 and out_valid never high.
```

Correction to the step-capture table above: the line for `di=1,dj=0` is garbled and should read:

```verilog
//   di=1,dj=0 : push {0,prev_a,1,0}  (up: gap in B)

Source files
------------

// File: rtl/alignment_stack.sv
// Alignment column stack.
//
// Converts the traceback walk (i,j) into aligned columns and reverses them with a LIFO.
// During FILL every coordinate change is classified as diag / up / left and the matching
// column is pushed. After end_c the stack is drained in forward order over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   en_traceB  traceback phase active; dropping it returns to IDLE from any state
//   end_c      traceback counter reached (0,0)
//   i, j       current traceback coordinates
//   char_a     sequence A symbol at position i
//   char_b     sequence B symbol at position j
//   out_valid  out_data holds a column (DRAIN only)
//   out_ready  consumer accepts the column
//   out_data   column {gap_a, chr_a, gap_b, chr_b}
//   out_last   out_data is the final column of the run
//   length     number of columns captured this run
//   done       drain complete, held until en_traceB falls
//   err        sticky illegal-step / overflow flag, cleared on the next run start
module alignment_stack #(
  parameter int unsigned N       = 128,
  parameter int unsigned BitAddr = $clog2(N + 1),
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned DEPTH   = 2 * N,
  parameter int unsigned PAIR_W  = 2 * (SYM_W + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_traceB,
  input  logic                         end_c,
  input  logic [BitAddr:0]             i,
  input  logic [BitAddr:0]             j,
  input  logic [SYM_W-1:0]             char_a,
  input  logic [SYM_W-1:0]             char_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAIR_W-1:0]            out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   length,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned CW    = BitAddr + 1;
  localparam int unsigned SpW   = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [SpW-1:0]   SpFull = SpW'(DEPTH);
  localparam logic [SpW-1:0]   SpOne  = SpW'(1);
  localparam logic [CW:0]      DZero  = '0;
  localparam logic [CW:0]      DOne   = (CW + 1)'(1);
  localparam logic [AddrW-1:0] AOne   = AddrW'(1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [SpW-1:0]       sp_q, sp_d;
  logic [SpW-1:0]       len_q, len_d;
  logic                 err_q, err_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [BitAddr:0]     prev_i_q, prev_i_d;
  logic [BitAddr:0]     prev_j_q, prev_j_d;
  logic [SYM_W-1:0]     prev_a_q, prev_a_d;
  logic [SYM_W-1:0]     prev_b_q, prev_b_d;

  logic [PAIR_W-1:0]    stack_q [DEPTH];

  // One bit wider than the coordinates so a backwards step underflows to a large value
  // instead of wrapping onto a legal 0/1.
  logic [CW:0]          di, dj;
  logic                 push;
  logic                 wr_en;
  logic [PAIR_W-1:0]    col;
  logic [AddrW-1:0]     rd_idx;

  assign di = {1'b0, prev_i_q} - {1'b0, i};
  assign dj = {1'b0, prev_j_q} - {1'b0, j};

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    len_d      = len_q;
    err_d      = err_q;
    prev_vld_d = prev_vld_q;
    prev_i_d   = prev_i_q;
    prev_j_d   = prev_j_q;
    prev_a_d   = prev_a_q;
    prev_b_d   = prev_b_q;
    push       = 1'b0;
    wr_en      = 1'b0;
    col        = '0;

    unique case (state_q)
      StIdle: begin
        if (en_traceB) begin
          state_d    = StFill;
          err_d      = 1'b0;
          sp_d       = '0;
          len_d      = '0;
          prev_vld_d = 1'b0;
        end
      end

      StFill: begin
        if (!en_traceB) begin
          state_d    = StIdle;
          sp_d       = '0;
          prev_vld_d = 1'b0;
        end else begin
          prev_vld_d = 1'b1;
          prev_i_d   = i;
          prev_j_d   = j;
          prev_a_d   = char_a;
          prev_b_d   = char_b;

          // The column belongs to the previous coordinate, hence prev_a/prev_b.
          if (prev_vld_q) begin
            if (di == DZero && dj == DZero) begin
              push = 1'b0;
            end else if (di == DOne && dj == DOne) begin
              push = 1'b1;
              col  = {1'b0, prev_a_q, 1'b0, prev_b_q};
            end else if (di == DOne && dj == DZero) begin
              push = 1'b1;
              col  = {1'b0, prev_a_q, 1'b1, {SYM_W{1'b0}}};
            end else if (di == DZero && dj == DOne) begin
              push = 1'b1;
              col  = {1'b1, {SYM_W{1'b0}}, 1'b0, prev_b_q};
            end else begin
              err_d = 1'b1;
            end
          end

          if (push) begin
            if (sp_q == SpFull) begin
              err_d = 1'b1;
            end else begin
              wr_en = 1'b1;
              sp_d  = sp_q + SpOne;
              len_d = len_q + SpOne;
            end
          end

          // A step arriving together with end_c is already counted in sp_d.
          if (end_c) begin
            state_d = (sp_d != '0) ? StDrain : StDone;
          end
        end
      end

      StDrain: begin
        if (!en_traceB) begin
          state_d = StIdle;
          sp_d    = '0;
        end else if (out_ready) begin
          sp_d = sp_q - SpOne;
          if (sp_q == SpOne) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (!en_traceB) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sp_q       <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      prev_vld_q <= 1'b0;
      prev_i_q   <= '0;
      prev_j_q   <= '0;
      prev_a_q   <= '0;
      prev_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      len_q      <= len_d;
      err_q      <= err_d;
      prev_vld_q <= prev_vld_d;
      prev_i_q   <= prev_i_d;
      prev_j_q   <= prev_j_d;
      prev_a_q   <= prev_a_d;
      prev_b_q   <= prev_b_d;
    end
  end

  // Storage needs no reset; sp_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_q[sp_q[AddrW-1:0]] <= col;
    end
  end

  assign rd_idx    = sp_q[AddrW-1:0] - AOne;
  assign out_valid = (state_q == StDrain);
  assign out_data  = out_valid ? stack_q[rd_idx] : '0;
  assign out_last  = out_valid && (sp_q == SpOne);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign length    = len_q;

endmodule

// File: tb/tb_alignment_stack.sv
module tb_alignment_stack;

  logic       clk;
  logic       rst;
  logic       en_traceB;
  logic       end_c;
  logic [3:0] i;
  logic [3:0] j;
  logic [1:0] char_a;
  logic [1:0] char_b;
  logic       out_ready;

  logic       out_valid, out_last, done, err;
  logic [5:0] out_data;
  logic [3:0] length;

  logic       out_valid4, out_last4, done4, err4;
  logic [5:0] out_data4;
  logic [2:0] length4;

  int checks = 0;
  int errors = 0;

  logic [1:0] seq_a [5];
  logic [1:0] seq_b [5];
  int         wc_i  [8];
  int         wc_j  [8];
  int         wn;
  logic [5:0] exp_col [8];
  int         exp_n;

  alignment_stack #(.N(4), .DEPTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en_traceB (en_traceB),
    .end_c     (end_c),
    .i         (i),
    .j         (j),
    .char_a    (char_a),
    .char_b    (char_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .length    (length),
    .done      (done),
    .err       (err)
  );

  alignment_stack #(.N(4), .DEPTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .en_traceB (en_traceB),
    .end_c     (end_c),
    .i         (i),
    .j         (j),
    .char_a    (char_a),
    .char_b    (char_b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .out_last  (out_last4),
    .length    (length4),
    .done      (done4),
    .err       (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] col(input logic ga, input logic [1:0] a, input logic gb,
                                     input logic [1:0] b);
    return {ga, a, gb, b};
  endfunction

  task automatic set_coord(input int ii, input int jj);
    i      = 4'(ii);
    j      = 4'(jj);
    char_a = seq_a[ii];
    char_b = seq_b[jj];
  endtask

  // Standard walk (4,4),(3,3),(2,3),(1,2),(0,1),(0,0).
  task automatic load_std_walk();
    wn = 6;
    wc_i[0] = 4; wc_j[0] = 4;
    wc_i[1] = 3; wc_j[1] = 3;
    wc_i[2] = 2; wc_j[2] = 3;
    wc_i[3] = 1; wc_j[3] = 2;
    wc_i[4] = 0; wc_j[4] = 1;
    wc_i[5] = 0; wc_j[5] = 0;
  endtask

  // Forward-order columns of the standard walk; skip drops the first (top) entries.
  task automatic load_std_exp(input int skip);
    logic [5:0] full [5];
    full[0] = col(1'b1, 2'd0, 1'b0, seq_b[1]);
    full[1] = col(1'b0, seq_a[1], 1'b0, seq_b[2]);
    full[2] = col(1'b0, seq_a[2], 1'b0, seq_b[3]);
    full[3] = col(1'b0, seq_a[3], 1'b1, 2'd0);
    full[4] = col(1'b0, seq_a[4], 1'b0, seq_b[4]);
    exp_n = 5 - skip;
    for (int k = 0; k < exp_n; k++) exp_col[k] = full[k + skip];
  endtask

  // Starts a run from IDLE; each coordinate is held 'hold' cycles, end_c on the very last.
  task automatic run_walk(input int hold);
    en_traceB = 1'b1;
    end_c     = 1'b0;
    set_coord(wc_i[0], wc_j[0]);
    cyc();
    for (int k = 0; k < wn; k++) begin
      set_coord(wc_i[k], wc_j[k]);
      for (int r = 0; r < hold; r++) begin
        end_c = (k == wn - 1) && (r == hold - 1);
        cyc();
      end
    end
    end_c = 1'b0;
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating.
  task automatic drain(input int sel, input int pat);
    int   idx;
    int   guard;
    logic rdy;
    logic ov, ol;
    logic [5:0] od;
    idx   = 0;
    guard = 0;
    while (idx < exp_n && guard < 64) begin
      rdy       = (pat == 0) ? 1'b1 : ((guard % 3) == 0);
      out_ready = rdy;
      ov = (sel == 0) ? out_valid : out_valid4;
      od = (sel == 0) ? out_data  : out_data4;
      ol = (sel == 0) ? out_last  : out_last4;
      chk("drain_valid", 32'(ov), 32'(1'b1));
      chk("drain_data", 32'(od), 32'(exp_col[idx]));
      chk("drain_last", 32'(ol), 32'(idx == exp_n - 1));
      cyc();
      if (rdy) idx++;
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: popped %0d expected %0d", idx, exp_n);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    seq_a[0] = 2'd0; seq_a[1] = 2'd1; seq_a[2] = 2'd2; seq_a[3] = 2'd3; seq_a[4] = 2'd2;
    seq_b[0] = 2'd0; seq_b[1] = 2'd3; seq_b[2] = 2'd1; seq_b[3] = 2'd0; seq_b[4] = 2'd2;

    rst       = 1'b0;
    en_traceB = 1'b0;
    end_c     = 1'b0;
    out_ready = 1'b0;
    i = '0; j = '0; char_a = '0; char_b = '0;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    cyc();

    // 1: basic walk, push on the end_c cycle; small DUT overflows on the 5th push
    load_std_walk();
    run_walk(1);
    chk("t1_length", 32'(length), 32'd5);
    chk("t1_err", 32'(err), 32'd0);
    chk("t5_err", 32'(err4), 32'd1);
    chk("t5_length", 32'(length4), 32'd4);
    load_std_exp(0);
    drain(0, 0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_after", 32'(out_valid), 32'd0);
    chk("t1_length_done", 32'(length), 32'd5);
    en_traceB = 1'b0;
    cyc();
    chk("t1_done_clear", 32'(done), 32'd0);

    // 2: every coordinate held 3 cycles
    run_walk(3);
    chk("t2_length", 32'(length), 32'd5);
    drain(0, 0);
    chk("t2_done", 32'(done), 32'd1);
    en_traceB = 1'b0;
    cyc();

    // 3: backpressure during drain
    run_walk(1);
    drain(0, 1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_length", 32'(length), 32'd5);
    en_traceB = 1'b0;
    cyc();

    // 5: DEPTH=4 instance drains only the 4 stored columns
    run_walk(1);
    chk("t5b_err", 32'(err4), 32'd1);
    chk("t5b_length", 32'(length4), 32'd4);
    load_std_exp(1);
    drain(1, 0);
    chk("t5_done", 32'(done4), 32'd1);
    chk("t5_valid_after", 32'(out_valid4), 32'd0);
    en_traceB = 1'b0;
    cyc();

    // 4: illegal jump (3,3)->(1,3)
    en_traceB = 1'b1;
    set_coord(4, 4);
    cyc();
    cyc();
    set_coord(3, 3);
    cyc();
    chk("t4_err_before", 32'(err), 32'd0);
    set_coord(1, 3);
    cyc();
    chk("t4_err_set", 32'(err), 32'd1);
    chk("t4_no_push", 32'(length), 32'd1);
    set_coord(0, 2);
    cyc();
    set_coord(0, 1);
    cyc();
    set_coord(0, 0);
    end_c = 1'b1;
    cyc();
    end_c = 1'b0;
    chk("t4_length", 32'(length), 32'd4);
    exp_n = 4;
    exp_col[0] = col(1'b1, 2'd0, 1'b0, seq_b[1]);
    exp_col[1] = col(1'b1, 2'd0, 1'b0, seq_b[2]);
    exp_col[2] = col(1'b0, seq_a[1], 1'b0, seq_b[3]);
    exp_col[3] = col(1'b0, seq_a[4], 1'b0, seq_b[4]);
    drain(0, 0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_err_done", 32'(err), 32'd1);
    en_traceB = 1'b0;
    cyc();
    chk("t4_err_idle", 32'(err), 32'd1);
    en_traceB = 1'b1;
    cyc();
    chk("t4_err_clear", 32'(err), 32'd0);
    en_traceB = 1'b0;
    cyc();

    // 6: async reset mid-drain, then an empty run
    run_walk(1);
    out_ready = 1'b0;
    cyc();
    chk("t6_in_drain", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_last", 32'(out_last), 32'd0);
    chk("t6_rst_length", 32'(length), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    en_traceB = 1'b0;
    #2;
    rst = 1'b1;
    cyc();
    en_traceB = 1'b1;
    end_c     = 1'b1;
    set_coord(4, 4);
    cyc();
    chk("t6_fill_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_length", 32'(length), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    en_traceB = 1'b0;
    end_c     = 1'b0;
    cyc();
    chk("t6_idle", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
